// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with optional two-entry skid,
// flush, NOP forcing of control bits on bubbles and a saturating bubble counter.
module pipe_stage_reg #(
   parameter int DATA_W = 123,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);
   localparam int W = CTRL_W + DATA_W;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t state_q, state_d;
   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic ready_q, ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic push, pop;
   assign out_valid  = state_q != EMPTY;
   assign in_ready   = (SKID != 0) ? ready_q : (!out_valid | out_ready);
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign out_ctrl   = out_valid ? main_q[W-1:DATA_W] : '0;
   assign out_data   = main_q[DATA_W-1:0];
   assign occupancy  = state_q;
   assign bubble_cnt = cnt_q;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) state_d = EMPTY;
      else if (state_q == FULL) begin
         if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
         end
      end else if (push) begin
         // Without SKID a push into ONE always coincides with a pop, so FULL is unreachable.
         if (state_q == ONE && !pop) begin
            state_d = FULL;
            skid_d  = {in_ctrl, in_data};
         end else begin
            state_d = ONE;
            main_d  = {in_ctrl, in_data};
         end
      end else if (pop) state_d = EMPTY;
      ready_d = state_d != FULL;
      cnt_d   = (out_ready && !out_valid && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table for the skid build plus hand sequences for
// counter saturation and the single-register build.
module tb_pipe_stage_reg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [15:0]   in_ctrl, out_ctrl;
   logic [122:0]  in_data, out_data;
   logic [1:0]    occupancy;
   logic [3:0]    bubble_cnt;

   logic          s_rst_n, s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [15:0]   s_in_ctrl, s_out_ctrl;
   logic [122:0]  s_in_data, s_out_data;
   logic [1:0]    s_occupancy;
   logic [15:0]   s_bubble_cnt;

   int checks = 0;
   int failures = 0;

   pipe_stage_reg #(.DATA_W(123), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(123), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_flat (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_ctrl(s_in_ctrl), .in_data(s_in_data), .flush(s_flush), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
      .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
   );

   typedef struct {
      logic         rst_n, in_valid, flush, out_ready;
      logic [15:0]  in_ctrl;
      logic [122:0] in_data;
      logic         e_ov;
      logic [15:0]  e_ctrl;
      logic [122:0] e_data;
      logic [1:0]   e_occ;
      logic         e_ir;
      logic [3:0]   e_bc;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input int idx, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, got, exp);
      end
   endtask

   initial begin
      s_rst_n = 0; s_in_valid = 0; s_flush = 0; s_out_ready = 0; s_in_ctrl = 0; s_in_data = 0;
      //           rst vld fl  ord ctrl      data      ov ctrl      data      occ ir bc
      tbl.push_back('{0, 1, 0, 1, 16'h0000, 123'h77, 0, 16'h0000, 123'h0,  0, 1, 0});
      tbl.push_back('{1, 1, 0, 1, 16'h0011, 123'h1,  1, 16'h0011, 123'h1,  1, 1, 1});
      tbl.push_back('{1, 1, 0, 1, 16'h0022, 123'h2,  1, 16'h0022, 123'h2,  1, 1, 1});
      tbl.push_back('{1, 1, 0, 1, 16'h0033, 123'h3,  1, 16'h0033, 123'h3,  1, 1, 1});
      tbl.push_back('{1, 1, 0, 1, 16'h0044, 123'h4,  1, 16'h0044, 123'h4,  1, 1, 1});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'h4,  0, 1, 1});
      tbl.push_back('{1, 1, 0, 0, 16'h00A0, 123'hA,  1, 16'h00A0, 123'hA,  1, 1, 1});
      tbl.push_back('{1, 1, 0, 0, 16'h00B0, 123'hB,  1, 16'h00A0, 123'hA,  2, 0, 1});
      tbl.push_back('{1, 1, 0, 0, 16'h00C0, 123'h5C, 1, 16'h00A0, 123'hA,  2, 0, 1});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  1, 16'h00B0, 123'hB,  1, 1, 1});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'hB,  0, 1, 1});
      tbl.push_back('{1, 1, 0, 0, 16'h0101, 123'h11, 1, 16'h0101, 123'h11, 1, 1, 1});
      tbl.push_back('{1, 1, 0, 0, 16'h0102, 123'h12, 1, 16'h0101, 123'h11, 2, 0, 1});
      tbl.push_back('{1, 1, 1, 0, 16'h0C0C, 123'hC,  0, 16'h0000, 123'h11, 0, 1, 1});
      tbl.push_back('{1, 1, 1, 0, 16'h0C0C, 123'hC,  0, 16'h0000, 123'h11, 0, 1, 1});
      tbl.push_back('{1, 0, 0, 0, 16'h0000, 123'h0,  0, 16'h0000, 123'h11, 0, 1, 1});
      tbl.push_back('{1, 1, 0, 1, 16'hFFFF, 123'hD,  1, 16'hFFFF, 123'hD,  1, 1, 2});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'hD,  0, 1, 2});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'hD,  0, 1, 3});
      tbl.push_back('{1, 0, 0, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'hD,  0, 1, 4});
      tbl.push_back('{1, 1, 0, 0, 16'h0001, 123'hE,  1, 16'h0001, 123'hE,  1, 1, 4});
      tbl.push_back('{1, 0, 1, 1, 16'h0000, 123'h0,  0, 16'h0000, 123'hE,  0, 1, 4});
      tbl.push_back('{1, 1, 0, 0, 16'h0002, 123'hF,  1, 16'h0002, 123'hF,  1, 1, 4});
      tbl.push_back('{0, 1, 0, 1, 16'h0003, 123'h9,  0, 16'h0000, 123'h0,  0, 1, 0});
      tbl.push_back('{1, 0, 0, 0, 16'h0000, 123'h0,  0, 16'h0000, 123'h0,  0, 1, 0});
      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n; in_valid = tbl[i].in_valid; flush = tbl[i].flush;
         out_ready = tbl[i].out_ready; in_ctrl = tbl[i].in_ctrl; in_data = tbl[i].in_data;
         @(posedge clk); #1;
         check("out_valid", i, {127'b0, out_valid}, {127'b0, tbl[i].e_ov});
         check("out_ctrl", i, {112'b0, out_ctrl}, {112'b0, tbl[i].e_ctrl});
         check("out_data", i, {5'b0, out_data}, {5'b0, tbl[i].e_data});
         check("occupancy", i, {126'b0, occupancy}, {126'b0, tbl[i].e_occ});
         check("in_ready", i, {127'b0, in_ready}, {127'b0, tbl[i].e_ir});
         check("bubble_cnt", i, {124'b0, bubble_cnt}, {124'b0, tbl[i].e_bc});
      end
      in_valid = 0; flush = 0; out_ready = 1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         check("sat_cnt", k, {124'b0, bubble_cnt}, (k > 15) ? 128'd15 : 128'(k));
      end

      s_rst_n = 0; s_out_ready = 0; s_in_valid = 1; s_in_data = 123'h99;
      @(posedge clk); #1;
      check("s_rst_ov", 0, {127'b0, s_out_valid}, 128'd0);
      check("s_rst_ir", 0, {127'b0, s_in_ready}, 128'd1);
      s_rst_n = 1; s_in_ctrl = 16'h0005; s_in_data = 123'h21;
      @(posedge clk); #1;
      check("s_push_ov", 1, {127'b0, s_out_valid}, 128'd1);
      check("s_push_data", 1, {5'b0, s_out_data}, 128'h21);
      check("s_stall_ir", 1, {127'b0, s_in_ready}, 128'd0);
      s_in_valid = 0;
      @(posedge clk); #1;
      check("s_hold_data", 2, {5'b0, s_out_data}, 128'h21);
      check("s_hold_occ", 2, {126'b0, s_occupancy}, 128'd1);
      s_out_ready = 1; #1;
      check("s_comb_ir", 3, {127'b0, s_in_ready}, 128'd1);
      s_in_valid = 1; s_in_ctrl = 16'h0006; s_in_data = 123'h22;
      @(posedge clk); #1;
      check("s_repl_data", 4, {5'b0, s_out_data}, 128'h22);
      check("s_repl_ctrl", 4, {112'b0, s_out_ctrl}, 128'h6);
      check("s_repl_occ", 4, {126'b0, s_occupancy}, 128'd1);
      s_in_data = 123'h23;
      @(posedge clk); #1;
      check("s_repl2_data", 5, {5'b0, s_out_data}, 128'h23);
      check("s_repl2_occ", 5, {126'b0, s_occupancy}, 128'd1);
      s_rst_n = 0;
      @(posedge clk); #1;
      check("s_mrst_ov", 6, {127'b0, s_out_valid}, 128'd0);
      check("s_mrst_ctrl", 6, {112'b0, s_out_ctrl}, 128'd0);
      check("s_mrst_data", 6, {5'b0, s_out_data}, 128'd0);
      check("s_mrst_occ", 6, {126'b0, s_occupancy}, 128'd0);
      check("s_mrst_bc", 6, {112'b0, s_bubble_cnt}, 128'd0);
      check("s_mrst_ir", 6, {127'b0, s_in_ready}, 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
